// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path.
// No logic; types and field indices only.
// Not applicable (no handshakes).
package bp_pkg;

    // Bit positions inside bp_upd_t.wen
    localparam int BP_WEN_BTB = 0;
    localparam int BP_WEN_BHT = 1;

    // One queued predictor update
    typedef struct packed {
        logic [1:0]  wen;
        logic        br;
        logic [31:0] pc;
        logic [31:0] target;
    } bp_upd_t;

    // Write-port drain states
    typedef enum logic {
        DRN_IDLE  = 1'b0,
        DRN_ISSUE = 1'b1
    } drn_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of predictor update records with head and head+1 lookahead.
// Latency: a push is readable at head the cycle after the push edge.
// Backpressure: full is count-based; pushes when full and pops when empty are ignored.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  bp_upd_t                  push_dat,
    input  logic                     pop,
    output bp_upd_t                  head_dat,
    output bp_upd_t                  next_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bp_upd_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];
    // Entry behind the head; lets the drain reload back-to-back on a pop
    assign next_dat = mem[rd_ptr + AW'(1)];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Mispredict redirect, predictor-update queueing/drain and branch statistics.
// Latency: redirect is combinational; an update reaches w_* two edges after acceptance.
// Backpressure: ex_ready drops when the update FIFO is full; w_* holds until wr_gnt.
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_hit,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    input  logic              wr_gnt,
    output logic [1:0]        w_en,
    output logic              br_in,
    output logic [31:0]       w_br_pc,
    output logic [31:0]       w_br_target,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_br,
    output logic [CNT_W-1:0]  stat_mis
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic         acc;
    logic         mis;
    logic         push;
    logic         pop;
    bp_upd_t      upd;
    bp_upd_t      head_dat;
    bp_upd_t      next_dat;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_cnt;
    drn_state_t   state_q;
    drn_state_t   state_d;
    bp_upd_t      w_q;
    bp_upd_t      w_d;

    // Readiness comes only from the registered count, never from a same-cycle pop
    assign ex_ready = ~fifo_full;
    assign acc      = ex_valid & ex_ready;
    assign mis      = (ex_pred_taken != ex_taken) |
                      (ex_taken & (ex_pred_target != ex_target));

    // Zero-latency redirect; fall-through PC wraps at 2^32
    always_comb begin
        redirect    = acc & mis;
        redirect_pc = 32'd0;
        if (redirect) begin
            redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
        end
    end

    // Build the update record from the resolved branch
    always_comb begin
        upd                 = '0;
        upd.wen[BP_WEN_BHT] = ex_pred_hit | ex_taken;
        upd.wen[BP_WEN_BTB] = ex_taken & (~ex_pred_hit | (ex_pred_target != ex_target));
        upd.br              = ex_taken;
        upd.pc              = ex_pc;
        upd.target          = ex_target;
    end

    // Records that write nothing are dropped here
    assign push = acc & (upd.wen != 2'b00);

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (upd),
        .pop      (pop),
        .head_dat (head_dat),
        .next_dat (next_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Drain next-state: load head on entry, reload next head on each grant
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        pop     = 1'b0;
        case (state_q)
            DRN_IDLE: begin
                if (!fifo_empty) begin
                    w_d     = head_dat;
                    state_d = DRN_ISSUE;
                end
            end
            DRN_ISSUE: begin
                if (wr_gnt) begin
                    pop = 1'b1;
                    if (fifo_cnt > CW'(1)) begin
                        w_d = next_dat;
                    end else if (push) begin
                        // Entry arriving this edge becomes the new head
                        w_d = upd;
                    end else begin
                        state_d = DRN_IDLE;
                    end
                end
            end
            default: begin
                state_d = DRN_IDLE;
            end
        endcase
    end

    // Drain state and write-port holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRN_IDLE;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
        end
    end

    assign w_en        = (state_q == DRN_ISSUE) ? w_q.wen : 2'b00;
    assign br_in       = w_q.br;
    assign w_br_pc     = w_q.pc;
    assign w_br_target = w_q.target;

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else if (stat_clr) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (acc && (stat_br != '1)) begin
                stat_br <= stat_br + CNT_W'(1);
            end
            if (acc && mis && (stat_mis != '1)) begin
                stat_mis <= stat_mis + CNT_W'(1);
            end
        end
    end

endmodule
